// File: rtl/vedic12_pp_combiner.sv
// Sequential combiner for the four 6x6 Vedic partial products of a 12x12 multiply.
// One shared 2N-bit carry-lookahead adder accumulates the aligned terms over three cycles.
module vedic12_pp_combiner #(
   parameter int unsigned N = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     pp_ll,
   input  logic [N-1:0]     pp_hl,
   input  logic [N-1:0]     pp_lh,
   input  logic [N-1:0]     pp_hh,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   product,
   output logic             ovf
);

   localparam int unsigned W = 2 * N;
   localparam int unsigned H = N / 2;

   typedef enum logic [2:0] {IDLE, ADD1, ADD2, ADD3, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [N-1:0]   hl_q, hl_d;
   logic [N-1:0]   lh_q, lh_d;
   logic [N-1:0]   hh_q, hh_d;
   logic           ovf_q, ovf_d;

   logic [W-1:0]   addend;
   logic [W-1:0]   sum;
   logic           cout;

   always_comb begin
      addend = '0;
      case (state_q)
         ADD1:    addend = {{N{1'b0}}, hl_q} << H;
         ADD2:    addend = {{N{1'b0}}, lh_q} << H;
         ADD3:    addend = {hh_q, {N{1'b0}}};
         default: addend = '0;
      endcase
   end

   // 4-bit lookahead blocks chained on block generate/propagate; W is a multiple of 4 since N is even.
   always_comb begin : cla
      logic [W-1:0] g;
      logic [W-1:0] p;
      logic [W:0]   c;
      g = acc_q & addend;
      p = acc_q ^ addend;
      c = '0;
      for (int unsigned grp = 0; grp < W / 4; grp++) begin
         c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
         c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                    | (p[4*grp+1] & p[4*grp] & c[4*grp]);
         c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                    | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                    | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
         c[4*grp+4] = (g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                    | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                    | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp]))
                    | ((&p[4*grp +: 4]) & c[4*grp]);
      end
      sum  = p ^ c[W-1:0];
      cout = c[W];
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      hl_d    = hl_q;
      lh_d    = lh_q;
      hh_d    = hh_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               hl_d    = pp_hl;
               lh_d    = pp_lh;
               hh_d    = pp_hh;
               acc_d   = {{N{1'b0}}, pp_ll};
               ovf_d   = 1'b0;
               state_d = ADD1;
            end
         end
         ADD1: begin
            acc_d   = sum;
            ovf_d   = ovf_q | cout;
            state_d = ADD2;
         end
         ADD2: begin
            acc_d   = sum;
            ovf_d   = ovf_q | cout;
            state_d = ADD3;
         end
         ADD3: begin
            acc_d   = sum;
            ovf_d   = ovf_q | cout;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         hl_q    <= '0;
         lh_q    <= '0;
         hh_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         hl_q    <= hl_d;
         lh_q    <= lh_d;
         hh_q    <= hh_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = acc_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_vedic12_pp_combiner.sv
// Directed bench for vedic12_pp_combiner: hand-computed products, latency, backpressure and reset abort.
module tb_vedic12_pp_combiner;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] pp_ll, pp_hl, pp_lh, pp_hh;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] product;
   logic        ovf;

   int unsigned n_vec;
   int unsigned n_miss;

   vedic12_pp_combiner #(.N(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pp_ll     (pp_ll),
      .pp_hl     (pp_hl),
      .pp_lh     (pp_lh),
      .pp_hh     (pp_hh),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      pp_ll = 12'($urandom());
      pp_hl = 12'($urandom());
      pp_lh = 12'($urandom());
      pp_hh = 12'($urandom());
   endtask

   // Full transaction with out_ready held high; inputs are scrambled after the accept edge.
   task automatic run_set(input string name, input logic [11:0] ll, input logic [11:0] hl,
                          input logic [11:0] lh, input logic [11:0] hh,
                          input logic [23:0] ep, input logic eo);
      check({name, "_rdy_pre"}, 32'(in_ready), 32'd1);
      pp_ll = ll; pp_hl = hl; pp_lh = lh; pp_hh = hh;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      scramble();
      check({name, "_rdy_k"}, 32'(in_ready), 32'd0);
      check({name, "_vld_k"}, 32'(out_valid), 32'd0);
      repeat (2) begin
         tick();
         check({name, "_vld_early"}, 32'(out_valid), 32'd0);
      end
      tick();
      check({name, "_vld_k3"}, 32'(out_valid), 32'd1);
      check({name, "_prod"}, 32'(product), 32'(ep));
      check({name, "_ovf"}, 32'(ovf), 32'(eo));
      check({name, "_rdy_k3"}, 32'(in_ready), 32'd0);
      tick();
      check({name, "_rdy_k4"}, 32'(in_ready), 32'd1);
      check({name, "_vld_k4"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_miss = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      pp_ll = '0; pp_hl = '0; pp_lh = '0; pp_hh = '0;
      repeat (2) tick();
      check("rst_rdy", 32'(in_ready), 32'd1);
      check("rst_vld", 32'(out_valid), 32'd0);
      check("rst_prod", 32'(product), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      tick();

      run_set("5x7",    12'd35,   12'd0,    12'd0,    12'd0,    24'h000023, 1'b0);
      run_set("64x64",  12'd0,    12'd0,    12'd0,    12'd1,    24'h001000, 1'b0);
      run_set("max",    12'd3969, 12'd3969, 12'd3969, 12'd3969, 24'hFFE001, 1'b0);
      run_set("illeg",  12'hFFF,  12'hFFF,  12'hFFF,  12'hFFF,  24'h07FF7F, 1'b1);
      run_set("after",  12'd35,   12'd0,    12'd0,    12'd0,    24'h000023, 1'b0);
      // 0x123 + 0x45<<6 + 0x67<<6 + 0x89<<12 = 0x123 + 0x1140 + 0x19C0 + 0x89000
      run_set("mix",    12'h123,  12'h045,  12'h067,  12'h089,  24'h08BC23, 1'b0);

      // Backpressure: hold DONE with in_valid high and toggling inputs.
      out_ready = 1'b0;
      pp_ll = 12'd35; pp_hl = '0; pp_lh = '0; pp_hh = '0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         scramble();
         check("bp_vld", 32'(out_valid), 32'd1);
         check("bp_prod", 32'(product), 32'h000023);
         check("bp_ovf", 32'(ovf), 32'd0);
         check("bp_rdy", 32'(in_ready), 32'd0);
         tick();
      end
      check("bp_vld_end", 32'(out_valid), 32'd1);
      check("bp_prod_end", 32'(product), 32'h000023);
      pp_ll = '0; pp_hl = '0; pp_lh = '0; pp_hh = 12'd1;
      out_ready = 1'b1;
      tick();
      check("bp_hs_vld", 32'(out_valid), 32'd0);
      check("bp_hs_rdy", 32'(in_ready), 32'd1);
      tick();
      check("bp_acc_rdy", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      scramble();
      repeat (2) begin
         tick();
         check("bp2_vld_early", 32'(out_valid), 32'd0);
      end
      tick();
      check("bp2_vld", 32'(out_valid), 32'd1);
      check("bp2_prod", 32'(product), 32'h001000);
      check("bp2_ovf", 32'(ovf), 32'd0);
      tick();
      check("bp2_rdy", 32'(in_ready), 32'd1);

      // Reset abort during ADD2.
      pp_ll = 12'hFFF; pp_hl = 12'hFFF; pp_lh = 12'hFFF; pp_hh = 12'hFFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("ra_vld", 32'(out_valid), 32'd0);
      check("ra_prod", 32'(product), 32'd0);
      check("ra_rdy", 32'(in_ready), 32'd1);
      check("ra_ovf", 32'(ovf), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ra_no_stale", 32'(out_valid), 32'd0);
      end
      run_set("post_rst", 12'd3969, 12'd3969, 12'd3969, 12'd3969, 24'hFFE001, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
